// File: rtl/freq_disp_pkg.sv
// Shared definitions for the frequency display: segment patterns, digit decoder, FSM states.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Segment patterns are active-low, bit [7] = dp, bits [6:0] = g..a; dp is off in every pattern.
package freq_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Non-decimal nibbles cannot come out of the converter; they decode to blank.
    function automatic logic [7:0] bcd2seg(input logic [3:0] nibble);
        logic [7:0] s;
        s = SEG_BLANK;
        if (nibble <= 4'd9) s = SEG_DIGIT[nibble];
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial binary-to-BCD converter (double-dabble), one input bit per cycle, MSB first.
// Latency: start accepted in IDLE; MAX conversion cycles then one LOAD cycle (done=1), busy for MAX+1.
// Backpressure: start is ignored while busy; bcd/ovf are valid while done is high.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start, bin    request a conversion of bin (accepted only when idle)
//   busy, done    conversion in progress / result valid this cycle
//   bcd, ovf      DIGITS BCD nibbles, ovf set when the value needs more than DIGITS digits
module bin2bcd_seq
    import freq_disp_pkg::*;
#(
    parameter int MAX    = 64,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MAX-1:0]        bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(MAX + 1);

    state_t          state;
    state_t          state_nx;
    logic [MAX-1:0]  sh;
    logic [BW-1:0]   acc;
    logic [BW-1:0]   adj;
    logic            acc_ovf;
    logic [CW-1:0]   cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CONV;
            CONV:    if (cnt == CW'(MAX - 1)) state_nx = LOAD;
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state != IDLE);
        done = (state == LOAD);
    end

    // Add-3 correction on every nibble >= 5 before the shift.
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Datapath. A 1 leaving the top nibble means the value has reached 10^DIGITS;
    // the flag is sticky because the partial value only grows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh      <= bin;
                        acc     <= '0;
                        acc_ovf <= 1'b0;
                        cnt     <= '0;
                    end
                end
                CONV: begin
                    acc     <= {adj[BW-2:0], sh[MAX-1]};
                    acc_ovf <= acc_ovf | adj[BW-1];
                    sh      <= {sh[MAX-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bcd = acc;
    assign ovf = acc_ovf;

endmodule

// File: rtl/freq_disp.sv
// Periodically samples frequency/point_index, converts to BCD and scans an 8-digit 7-seg display.
// Latency: sample on refresh tick, display updated MAX+1 cycles later; seg/sel registered one cycle after digit index.
// Backpressure: refresh ticks arriving while a conversion runs are dropped.
//
// Ports:
//   clk_fs       only clock
//   rst          asynchronous, active-high reset
//   frequency    binary value to display
//   point_index  number of fractional digits (0 = no decimal point)
//   seg          segments, active-low, [7]=dp, [6:0]=g..a
//   sel          digit enables, active-low, one-hot-low (digit 0 = rightmost)
//   busy         conversion in progress
//   overflow     last converted value did not fit in DIGITS digits
// Build option: define LZB_EN for leading-zero blanking; otherwise every digit is shown.
module freq_disp
    import freq_disp_pkg::*;
#(
    parameter int MAX         = 64,
    parameter int DIGITS      = 8,
    parameter int SCAN_DIV    = 100000,
    parameter int REFRESH_DIV = 10000000
) (
    input  logic              clk_fs,
    input  logic              rst,
    input  logic [MAX-1:0]    frequency,
    input  logic [3:0]        point_index,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] sel,
    output logic              busy,
    output logic              overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [RW-1:0]     refresh_cnt;
    logic              tick;
    logic              conv_busy;
    logic              conv_done;
    logic [BW-1:0]     conv_bcd;
    logic              conv_ovf;
    logic [3:0]        pidx_lat;

    logic [BW-1:0]     disp_bcd;
    logic              disp_ovf;
    logic [3:0]        disp_pidx;

    logic [SW-1:0]     scan_cnt;
    logic [DW-1:0]     digit_idx;
    logic [3:0]        cur_nib;
    logic              dp_here;
    logic [7:0]        seg_nx;
    logic [DIGITS-1:0] sel_nx;

    // Refresh timer
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign tick = (refresh_cnt == RW'(REFRESH_DIV - 1));

    bin2bcd_seq #(
        .MAX    (MAX),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk_fs),
        .rst   (rst),
        .start (tick),
        .bin   (frequency),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    assign busy = conv_busy;

    // point_index is captured under the same condition the converter accepts start,
    // so it always belongs to the value being converted.
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            pidx_lat <= '0;
        end else if (tick && !conv_busy) begin
            pidx_lat <= point_index;
        end
    end

    // Display registers: all three update together so the scan never sees a mixed result.
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            disp_bcd  <= '0;
            disp_ovf  <= 1'b0;
            disp_pidx <= '0;
        end else if (conv_done) begin
            disp_bcd  <= conv_bcd;
            disp_ovf  <= conv_ovf;
            disp_pidx <= pidx_lat;
        end
    end

    assign overflow = disp_ovf;

    // Digit scan
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == DW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
        end
    end

`ifdef LZB_EN
    // upper_zero: current digit and every digit to its left are zero.
    logic upper_zero;
    logic zero_run;

    always_comb begin
        zero_run   = 1'b1;
        upper_zero = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_bcd[4*i +: 4] == 4'd0);
            if (i == int'(digit_idx)) upper_zero = zero_run;
        end
    end
`endif

    always_comb begin
        cur_nib = disp_bcd[4*int'(digit_idx) +: 4];
        dp_here = (disp_pidx != 4'd0) && (int'(disp_pidx) <= DIGITS - 1) &&
                  (int'(disp_pidx) == int'(digit_idx));
        seg_nx  = SEG_BLANK;
        if (disp_ovf) begin
            seg_nx = SEG_DASH;
        end else begin
            seg_nx = bcd2seg(cur_nib);
            if (dp_here) seg_nx[7] = 1'b0;
`ifdef LZB_EN
            if ((digit_idx != '0) && (int'(digit_idx) > int'(disp_pidx)) && upper_zero)
                seg_nx = SEG_BLANK;
`endif
        end
        sel_nx = ~(DIGITS'(1) << digit_idx);
    end

    // seg and sel share one register stage so they always switch on the same edge.
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            sel <= '1;
        end else begin
            seg <= seg_nx;
            sel <= sel_nx;
        end
    end

endmodule

// File: tb/tb_freq_disp.sv
// Directed bench for freq_disp with SCAN_DIV=4, REFRESH_DIV=200.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_freq_disp;

    logic        clk_fs = 1'b0;
    logic        rst    = 1'b1;
    logic [63:0] frequency   = '0;
    logic [3:0]  point_index = '0;
    logic [7:0]  seg;
    logic [7:0]  sel;
    logic        busy;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_seg [8];

    always #5 clk_fs = ~clk_fs;

    freq_disp #(
        .MAX         (64),
        .DIGITS      (8),
        .SCAN_DIV    (4),
        .REFRESH_DIV (200)
    ) dut (
        .clk_fs      (clk_fs),
        .rst         (rst),
        .frequency   (frequency),
        .point_index (point_index),
        .seg         (seg),
        .sel         (sel),
        .busy        (busy),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Waits for a fresh conversion to start (busy low, then high).
    task automatic wait_rise(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge clk_fs);
            n++;
        end
        while (busy !== 1'b1 && n < 400) begin
            @(negedge clk_fs);
            n++;
        end
        chk({tag, "_start_seen"}, 64'(n < 400), 64'd1);
    endtask

    // Counts busy-high cycles starting at the first negedge where busy is high.
    task automatic wait_fall(input string tag);
        int len;
        len = 0;
        while (busy === 1'b1 && len < 200) begin
            @(negedge clk_fs);
            len++;
        end
        chk({tag, "_busy_len"}, 64'(len), 64'd65);
    endtask

    // Checks each digit's pattern as the scan reaches it, in scan order 0..7.
    task automatic check_digits(input string tag);
        logic [7:0] pat;
        int n;
        for (int i = 0; i < 8; i++) begin
            pat = ~(8'h01 << i);
            n = 0;
            while (sel !== pat && n < 40) begin
                @(negedge clk_fs);
                n++;
            end
            chk($sformatf("%s_d%0d", tag, i), {48'd0, sel, seg}, {48'd0, pat, exp_seg[i]});
        end
    endtask

    initial begin
        int n;
        logic [7:0] pat;

        // Reset state
        repeat (3) @(negedge clk_fs);
        chk("rst_seg", 64'(seg), 64'hFF);
        chk("rst_sel", 64'(sel), 64'hFF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk_fs);
        chk("post_rst_sel", 64'(sel), 64'hFE);
        chk("post_rst_seg", 64'(seg), 64'hC0);

        // 1: 12345678, no point
        frequency = 64'd12345678;
        point_index = 4'd0;
        wait_rise("t1");
        wait_fall("t1");
        chk("t1_ovf", 64'(overflow), 64'd0);
        exp_seg = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        check_digits("t1");

        // 2: 500 with two fractional digits
        frequency = 64'd500;
        point_index = 4'd2;
        wait_rise("t2");
        wait_fall("t2");
`ifdef LZB_EN
        exp_seg = '{8'hC0, 8'hC0, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
        exp_seg = '{8'hC0, 8'hC0, 8'h12, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        check_digits("t2");

        // 3a: 10^8 overflows; dp suppressed
        frequency = 64'd100000000;
        point_index = 4'd3;
        wait_rise("t3a");
        wait_fall("t3a");
        chk("t3a_ovf", 64'(overflow), 64'd1);
        exp_seg = '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
        check_digits("t3a");

        // 5: reset 20 cycles into a conversion of 99999999
        frequency = 64'd99999999;
        point_index = 4'd0;
        wait_rise("t5");
        repeat (20) @(negedge clk_fs);
        rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_seg", 64'(seg), 64'hFF);
        chk("t5_sel", 64'(sel), 64'hFF);
        chk("t5_ovf", 64'(overflow), 64'd0);
        @(negedge clk_fs);
        rst = 1'b0;
        @(negedge clk_fs);
        chk("t5_clr_sel", 64'(sel), 64'hFE);
        chk("t5_clr_seg", 64'(seg), 64'hC0);
        n = 1;
        while (busy !== 1'b1 && n < 400) begin
            @(negedge clk_fs);
            n++;
        end
        chk("t5_restart_delay", 64'(n), 64'd200);
        wait_fall("t5");

        // 3b: 99999999 just fits
        chk("t3b_ovf", 64'(overflow), 64'd0);
        exp_seg = '{8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90};
        check_digits("t3b");

        // 4: zero with one fractional digit
        frequency = 64'd0;
        point_index = 4'd1;
        wait_rise("t4");
        wait_fall("t4");
`ifdef LZB_EN
        exp_seg = '{8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
        exp_seg = '{8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        check_digits("t4");

        // 6a: scan order and period
        n = 0;
        while (sel !== 8'h7F && n < 100) begin
            @(negedge clk_fs);
            n++;
        end
        while (sel !== 8'hFE && n < 100) begin
            @(negedge clk_fs);
            n++;
        end
        chk("t6_scan_sync", 64'(n < 100), 64'd1);
        for (int s = 0; s < 9; s++) begin
            pat = ~(8'h01 << (s % 8));
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("t6_scan_s%0d_c%0d", s, c), 64'(sel), 64'(pat));
                @(negedge clk_fs);
            end
        end

        // 6b: inputs changed mid-conversion must not reach the display; p=8 gives no dp
        frequency = 64'd87654321;
        point_index = 4'd8;
        wait_rise("t6");
        frequency = 64'd11111111;
        point_index = 4'd3;
        wait_fall("t6");
        chk("t6_ovf", 64'(overflow), 64'd0);
        exp_seg = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
        check_digits("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
